// File: rtl/brick_field_engine.sv
// Brick-wall engine: per-brick hit-points, per-pixel wall drawing, and a once-per-frame
// sequential ball/brick collision scan that reports which velocity axis to reverse.
module brick_field_engine #(
   parameter int          NUM_ROWS   = 6,
   parameter int          NUM_COLS   = 8,
   parameter int          BRICK_W    = 35,
   parameter int          BRICK_H    = 70,
   parameter int          GAP        = 2,
   parameter int          REGION_X_L = 40,
   parameter int          REGION_Y_T = 30,
   parameter int          BALL_SIZE  = 8,
   parameter int          HP_BITS    = 2,
   parameter int          HP_INIT    = 2,
   parameter logic [11:0] C_HP1      = 12'hf00,
   parameter logic [11:0] C_HP2      = 12'hff0,
   parameter logic [11:0] C_HPX      = 12'h0ff,
   localparam int         NUM_BRICKS = NUM_ROWS * NUM_COLS,
   localparam int         IDX_W      = $clog2(NUM_BRICKS),
   localparam int         CNT_W      = $clog2(NUM_BRICKS + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             level_start,
   input  logic             refr_tick,
   input  logic [9:0]       ball_x_l,
   input  logic [9:0]       ball_y_t,
   input  logic [9:0]       pix_x,
   input  logic [9:0]       pix_y,
   output logic             brick_on,
   output logic [11:0]      brick_rgb,
   output logic             scan_busy,
   output logic             hit,
   output logic             bounce_x,
   output logic             bounce_y,
   output logic [IDX_W-1:0] hit_index,
   output logic [CNT_W-1:0] bricks_left,
   output logic             level_clear
);
   localparam int CW    = 12;
   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   localparam logic [CW-1:0]      X_L_C    = CW'(REGION_X_L);
   localparam logic [CW-1:0]      Y_T_C    = CW'(REGION_Y_T);
   localparam logic [CW-1:0]      BW_C     = CW'(BRICK_W);
   localparam logic [CW-1:0]      BH_C     = CW'(BRICK_H);
   localparam logic [CW-1:0]      BW_ON_C  = CW'(BRICK_W - GAP);
   localparam logic [CW-1:0]      BH_ON_C  = CW'(BRICK_H - GAP);
   localparam logic [CW-1:0]      WALL_W_C = CW'(NUM_COLS * BRICK_W);
   localparam logic [CW-1:0]      WALL_H_C = CW'(NUM_ROWS * BRICK_H);
   localparam logic [CW-1:0]      BALL_C   = CW'(BALL_SIZE - 1);
   localparam logic [CW-1:0]      NCOLS_C  = CW'(NUM_COLS);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BRICKS - 1);
   localparam logic [COL_W-1:0]   COL_LAST = COL_W'(NUM_COLS - 1);
   localparam logic [HP_BITS-1:0] HP_LOAD  = HP_BITS'(HP_INIT);
   localparam logic [CNT_W-1:0]   ALL_CNT  = CNT_W'(NUM_BRICKS);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_REPORT} state_t;

   state_t             state_q, state_d;
   logic [HP_BITS-1:0] hp_q [NUM_BRICKS];
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               rep_x_q, rep_x_d;
   logic               hit_q, hit_d;
   logic               bounce_x_q, bounce_x_d;
   logic               bounce_y_q, bounce_y_d;
   logic [IDX_W-1:0]   hit_index_q, hit_index_d;
   logic [CNT_W-1:0]   bricks_left_q, bricks_left_d;
   logic               level_clear_q, level_clear_d;

   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic [HP_BITS-1:0] wr_data;

   // Geometry of the brick currently addressed by the scan pointer.
   logic [CW-1:0]      brk_l, brk_r, brk_t, brk_b;
   logic [CW-1:0]      ball_l, ball_r, ball_t, ball_b;
   logic [HP_BITS-1:0] scan_hp;
   logic               overlap, axis_y;

   always_comb begin
      brk_l   = X_L_C + CW'(col_q) * BW_C;
      brk_r   = brk_l + BW_C - CW'(1);
      brk_t   = Y_T_C + CW'(row_q) * BH_C;
      brk_b   = brk_t + BH_C - CW'(1);
      ball_l  = CW'(ball_x_l);
      ball_r  = ball_l + BALL_C;
      ball_t  = CW'(ball_y_t);
      ball_b  = ball_t + BALL_C;
      scan_hp = hp_q[idx_q];
      overlap = (scan_hp != '0) && (brk_l <= ball_r) && (ball_l <= brk_r)
                && (brk_t <= ball_b) && (ball_t <= brk_b);
      // Strict horizontal overlap means the ball met a top/bottom face; edge or corner contact bounces in x.
      axis_y  = (brk_l < ball_r) && (ball_l < brk_r);
   end

   logic [IDX_W-1:0] idx_inc;
   logic [COL_W-1:0] col_inc;
   logic [ROW_W-1:0] row_inc;

   always_comb begin
      idx_inc = idx_q + IDX_W'(1);
      col_inc = col_q + COL_W'(1);
      row_inc = row_q;
      if (col_q == COL_LAST) begin
         col_inc = '0;
         row_inc = row_q + ROW_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      col_d         = col_q;
      row_d         = row_q;
      rep_x_d       = rep_x_q;
      hit_d         = 1'b0;
      bounce_x_d    = 1'b0;
      bounce_y_d    = 1'b0;
      hit_index_d   = hit_index_q;
      bricks_left_d = bricks_left_q;
      level_clear_d = level_clear_q;
      wr_en         = 1'b0;
      wr_idx        = idx_q;
      wr_data       = HP_LOAD;
      if (level_start) begin
         state_d       = S_LOAD;
         idx_d         = '0;
         col_d         = '0;
         row_d         = '0;
         level_clear_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (refr_tick) begin
                  state_d = S_SCAN;
                  idx_d   = '0;
                  col_d   = '0;
                  row_d   = '0;
               end
            end
            S_LOAD: begin
               wr_en   = 1'b1;
               wr_data = HP_LOAD;
               if (idx_q == LAST_IDX) begin
                  state_d       = S_IDLE;
                  bricks_left_d = ALL_CNT;
                  level_clear_d = 1'b0;
               end else begin
                  idx_d = idx_inc;
                  col_d = col_inc;
                  row_d = row_inc;
               end
            end
            S_SCAN: begin
               if (overlap) begin
                  state_d = S_REPORT;
                  rep_x_d = !axis_y;
               end else if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_inc;
                  col_d = col_inc;
                  row_d = row_inc;
               end
            end
            S_REPORT: begin
               state_d     = S_IDLE;
               hit_d       = 1'b1;
               bounce_x_d  = rep_x_q;
               bounce_y_d  = !rep_x_q;
               hit_index_d = idx_q;
               wr_en       = 1'b1;
               wr_data     = scan_hp - HP_BITS'(1);
               if (scan_hp == HP_BITS'(1)) begin
                  bricks_left_d = bricks_left_q - CNT_W'(1);
                  if (bricks_left_q == CNT_W'(1)) level_clear_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         rep_x_q       <= 1'b0;
         hit_q         <= 1'b0;
         bounce_x_q    <= 1'b0;
         bounce_y_q    <= 1'b0;
         hit_index_q   <= '0;
         bricks_left_q <= '0;
         level_clear_q <= 1'b0;
         for (int i = 0; i < NUM_BRICKS; i++) hp_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         col_q         <= col_d;
         row_q         <= row_d;
         rep_x_q       <= rep_x_d;
         hit_q         <= hit_d;
         bounce_x_q    <= bounce_x_d;
         bounce_y_q    <= bounce_y_d;
         hit_index_q   <= hit_index_d;
         bricks_left_q <= bricks_left_d;
         level_clear_q <= level_clear_d;
         if (wr_en) hp_q[wr_idx] <= wr_data;
      end
   end

   // Pixel path: purely combinational second read port into the hit-point array.
   logic [CW-1:0]      px, py, dx, dy, pcol, prow, offx, offy;
   logic               in_wall;
   logic [IDX_W-1:0]   pix_idx;
   logic [HP_BITS-1:0] pix_hp;

   always_comb begin
      px      = CW'(pix_x);
      py      = CW'(pix_y);
      dx      = px - X_L_C;
      dy      = py - Y_T_C;
      in_wall = (px >= X_L_C) && (dx < WALL_W_C) && (py >= Y_T_C) && (dy < WALL_H_C);
      pcol    = dx / BW_C;
      prow    = dy / BH_C;
      offx    = dx - pcol * BW_C;
      offy    = dy - prow * BH_C;
      pix_idx = '0;
      if (in_wall) pix_idx = IDX_W'(prow * NCOLS_C + pcol);
      pix_hp    = hp_q[pix_idx];
      brick_on  = in_wall && (offx < BW_ON_C) && (offy < BH_ON_C) && (pix_hp != '0);
      brick_rgb = 12'h000;
      if (brick_on) begin
         if (pix_hp == HP_BITS'(1))      brick_rgb = C_HP1;
         else if (pix_hp == HP_BITS'(2)) brick_rgb = C_HP2;
         else                            brick_rgb = C_HPX;
      end
   end

   assign scan_busy   = (state_q == S_LOAD) || (state_q == S_SCAN);
   assign hit         = hit_q;
   assign bounce_x    = bounce_x_q;
   assign bounce_y    = bounce_y_q;
   assign hit_index   = hit_index_q;
   assign bricks_left = bricks_left_q;
   assign level_clear = level_clear_q;

endmodule

// File: tb/tb_brick_field_engine.sv
// Directed bench for brick_field_engine: a default instance (HP_INIT=2) and a one-hit
// instance (HP_INIT=1) used to clear a whole level.
module tb_brick_field_engine;
   localparam int LINE_CYCLES = 800;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, rst1_n;
   logic       level_start, refr_tick, level_start1, refr_tick1;
   logic [9:0] ball_x_l, ball_y_t, ball_x_l1, ball_y_t1, pix_x, pix_y;

   logic        brick_on, scan_busy, hit, bounce_x, bounce_y, level_clear;
   logic [11:0] brick_rgb;
   logic [5:0]  hit_index, bricks_left;
   logic        brick_on1, scan_busy1, hit1, bounce_x1, bounce_y1, level_clear1;
   logic [11:0] brick_rgb1;
   logic [5:0]  hit_index1, bricks_left1;

   int total = 0;
   int bad   = 0;

   brick_field_engine u_dut (
      .clk(clk), .reset_n(reset_n), .level_start(level_start), .refr_tick(refr_tick),
      .ball_x_l(ball_x_l), .ball_y_t(ball_y_t), .pix_x(pix_x), .pix_y(pix_y),
      .brick_on(brick_on), .brick_rgb(brick_rgb), .scan_busy(scan_busy), .hit(hit),
      .bounce_x(bounce_x), .bounce_y(bounce_y), .hit_index(hit_index),
      .bricks_left(bricks_left), .level_clear(level_clear)
   );

   brick_field_engine #(.HP_INIT(1)) u_dut1 (
      .clk(clk), .reset_n(rst1_n), .level_start(level_start1), .refr_tick(refr_tick1),
      .ball_x_l(ball_x_l1), .ball_y_t(ball_y_t1), .pix_x(pix_x), .pix_y(pix_y),
      .brick_on(brick_on1), .brick_rgb(brick_rgb1), .scan_busy(scan_busy1), .hit(hit1),
      .bounce_x(bounce_x1), .bounce_y(bounce_y1), .hit_index(hit_index1),
      .bricks_left(bricks_left1), .level_clear(level_clear1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int x, input int y);
      pix_x = 10'(x);
      pix_y = 10'(y);
      #1;
   endtask

   // Tick the main instance with the ball at (bx,by); lat = cycles from tick to hit, 0 if none.
   task automatic strike(input int bx, input int by, input int limit, output int lat);
      ball_x_l  = 10'(bx);
      ball_y_t  = 10'(by);
      refr_tick = 1'b1;
      step();
      refr_tick = 1'b0;
      lat = 0;
      for (int n = 1; n <= limit; n++) begin
         step();
         if (hit) begin
            lat = n;
            break;
         end
      end
      $display("strike ball=(%0d,%0d) lat=%0d idx=%0d bx=%0b by=%0b left=%0d",
               bx, by, lat, hit_index, bounce_x, bounce_y, bricks_left);
   endtask

   // Reload the main instance; optionally fire refr_tick mid-load (must be ignored).
   task automatic load_main(input bit poke_tick, output int busy_cycles, output bit saw_hit);
      level_start = 1'b1;
      step();
      level_start = 1'b0;
      busy_cycles = 0;
      saw_hit     = 1'b0;
      while (scan_busy && busy_cycles < 200) begin
         busy_cycles++;
         refr_tick = poke_tick && (busy_cycles == 10);
         step();
         if (hit) saw_hit = 1'b1;
      end
      refr_tick = 1'b0;
      $display("load busy=%0d left=%0d", busy_cycles, bricks_left);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rst1_n  = 1'b0;
      step();
      step();
      total++; if ({hit, bounce_x, bounce_y, scan_busy, level_clear} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b want=00000", {hit, bounce_x, bounce_y, scan_busy, level_clear}); end
      total++; if (hit_index !== 6'd0) begin bad++; $display("FAIL reset_hit_index got=%0d want=0", hit_index); end
      total++; if (bricks_left !== 6'd0) begin bad++; $display("FAIL reset_bricks_left got=%0d want=0", bricks_left); end
      probe(41, 31);
      total++; if (brick_on !== 1'b0) begin bad++; $display("FAIL reset_brick_on got=%b want=0", brick_on); end
      reset_n = 1'b1;
      rst1_n  = 1'b1;
      step();
   endtask

   task automatic test_load();
      int cyc;
      bit saw;
      int px[8]  = '{41, 72, 73, 41, 41, 317, 39, 41};
      int py[8]  = '{31, 31, 31, 97, 98, 447, 31, 450};
      bit on[8]  = '{1, 1, 0, 1, 0, 1, 0, 0};
      load_main(1'b1, cyc, saw);
      total++; if (cyc !== 48) begin bad++; $display("FAIL load_busy got=%0d want=48", cyc); end
      total++; if (saw !== 1'b0) begin bad++; $display("FAIL load_tick_ignored got_hit=%b want=0", saw); end
      total++; if (bricks_left !== 6'd48) begin bad++; $display("FAIL load_bricks_left got=%0d want=48", bricks_left); end
      total++; if (level_clear !== 1'b0) begin bad++; $display("FAIL load_level_clear got=%b want=0", level_clear); end
      for (int i = 0; i < 8; i++) begin
         probe(px[i], py[i]);
         total++; if (brick_on !== on[i] || brick_rgb !== (on[i] ? 12'hff0 : 12'h000)) begin
            bad++; $display("FAIL load_pixel(%0d,%0d) got on=%b rgb=%h want on=%b rgb=%h",
                            px[i], py[i], brick_on, brick_rgb, on[i], on[i] ? 12'hff0 : 12'h000); end
      end
   endtask

   task automatic test_hit_brick0();
      int lat;
      for (int k = 1; k <= 2; k++) begin
         strike(50, 96, 60, lat);
         total++; if (lat !== 2) begin bad++; $display("FAIL hit%0d_latency got=%0d want=2", k, lat); end
         total++; if (hit_index !== 6'd0) begin bad++; $display("FAIL hit%0d_index got=%0d want=0", k, hit_index); end
         total++; if ({bounce_x, bounce_y} !== 2'b01) begin
            bad++; $display("FAIL hit%0d_axis got=%b want=01", k, {bounce_x, bounce_y}); end
         total++; if (bricks_left !== ((k == 1) ? 6'd48 : 6'd47)) begin
            bad++; $display("FAIL hit%0d_bricks_left got=%0d want=%0d", k, bricks_left, (k == 1) ? 48 : 47); end
         step();
         total++; if (hit !== 1'b0) begin bad++; $display("FAIL hit%0d_pulse got=%b want=0", k, hit); end
         probe(41, 31);
         total++; if (brick_on !== (k == 1) || brick_rgb !== ((k == 1) ? 12'hf00 : 12'h000)) begin
            bad++; $display("FAIL hit%0d_pixel got on=%b rgb=%h want on=%b rgb=%h", k, brick_on, brick_rgb,
                            k == 1, (k == 1) ? 12'hf00 : 12'h000); end
      end
      probe(41, 101);
      total++; if (brick_rgb !== 12'hff0) begin bad++; $display("FAIL brick8_rgb got=%h want=ff0", brick_rgb); end
   endtask

   task automatic test_dead_brick();
      int lat;
      strike(50, 40, 60, lat);
      total++; if (lat !== 0) begin bad++; $display("FAIL dead_brick_hit got_lat=%0d want=0", lat); end
      total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL dead_brick_busy got=%b want=0", scan_busy); end
      total++; if (bricks_left !== 6'd47) begin bad++; $display("FAIL dead_brick_left got=%0d want=47", bricks_left); end
   endtask

   task automatic test_worst_latency();
      int lat;
      strike(295, 400, 100, lat);
      total++; if (lat !== 49) begin bad++; $display("FAIL worst_latency got=%0d want=49", lat); end
      total++; if (hit_index !== 6'd47) begin bad++; $display("FAIL worst_index got=%0d want=47", hit_index); end
      total++; if (!(lat > 0 && lat < LINE_CYCLES)) begin
         bad++; $display("FAIL line_budget got=%0d want=1..%0d", lat, LINE_CYCLES - 1); end
      a_line_budget: assert (lat < LINE_CYCLES);
   endtask

   task automatic test_edge_axis();
      int cyc, lat;
      bit saw;
      load_main(1'b0, cyc, saw);
      total++; if (bricks_left !== 6'd48) begin bad++; $display("FAIL reload_left got=%0d want=48", bricks_left); end
      // Strictly inside brick 0 horizontally (also touching brick 1): lowest index, y bounce.
      strike(71, 60, 60, lat);
      total++; if (lat !== 2 || hit_index !== 6'd0 || {bounce_x, bounce_y} !== 2'b01) begin
         bad++; $display("FAIL straddle got lat=%0d idx=%0d xy=%b want lat=2 idx=0 xy=01", lat, hit_index, {bounce_x, bounce_y}); end
      // Ball left edge exactly on brick 0 right edge: edge contact, x bounce, kills brick 0.
      strike(74, 60, 60, lat);
      total++; if (lat !== 2 || hit_index !== 6'd0 || {bounce_x, bounce_y} !== 2'b10) begin
         bad++; $display("FAIL edge got lat=%0d idx=%0d xy=%b want lat=2 idx=0 xy=10", lat, hit_index, {bounce_x, bounce_y}); end
      total++; if (bricks_left !== 6'd47) begin bad++; $display("FAIL edge_left got=%0d want=47", bricks_left); end
      strike(74, 60, 60, lat);
      total++; if (lat !== 3 || hit_index !== 6'd1 || {bounce_x, bounce_y} !== 2'b01) begin
         bad++; $display("FAIL next_brick got lat=%0d idx=%0d xy=%b want lat=3 idx=1 xy=01", lat, hit_index, {bounce_x, bounce_y}); end
   endtask

   task automatic test_reset_mid_scan();
      int px[3] = '{41, 100, 317};
      int py[3] = '{31, 200, 447};
      ball_x_l  = 10'd295;
      ball_y_t  = 10'd400;
      refr_tick = 1'b1;
      step();
      refr_tick = 1'b0;
      repeat (5) step();
      total++; if (scan_busy !== 1'b1) begin bad++; $display("FAIL mid_scan_busy got=%b want=1", scan_busy); end
      reset_n = 1'b0;
      #1;
      total++; if ({hit, bounce_x, bounce_y, scan_busy, level_clear} !== 5'b0 || hit_index !== 6'd0) begin
         bad++; $display("FAIL mid_reset_flags got=%b idx=%0d want=00000 idx=0",
                         {hit, bounce_x, bounce_y, scan_busy, level_clear}, hit_index); end
      total++; if (bricks_left !== 6'd0) begin bad++; $display("FAIL mid_reset_left got=%0d want=0", bricks_left); end
      for (int i = 0; i < 3; i++) begin
         probe(px[i], py[i]);
         total++; if (brick_on !== 1'b0) begin
            bad++; $display("FAIL mid_reset_pixel(%0d,%0d) got=%b want=0", px[i], py[i], brick_on); end
      end
      step();
      reset_n = 1'b1;
      repeat (3) step();
      total++; if (hit !== 1'b0 || scan_busy !== 1'b0) begin
         bad++; $display("FAIL post_reset got hit=%b busy=%b want 0 0", hit, scan_busy); end
   endtask

   task automatic test_level_clear();
      int cyc, lat;
      bit saw;
      level_start1 = 1'b1;
      step();
      level_start1 = 1'b0;
      cyc = 0;
      while (scan_busy1 && cyc < 200) begin cyc++; step(); end
      total++; if (bricks_left1 !== 6'd48) begin bad++; $display("FAIL lc_load_left got=%0d want=48", bricks_left1); end
      for (int i = 0; i < 48; i++) begin
         ball_x_l1  = 10'(40 + (i % 8) * 35 + 10);
         ball_y_t1  = 10'(30 + (i / 8) * 70 + 20);
         refr_tick1 = 1'b1;
         step();
         refr_tick1 = 1'b0;
         lat = 0;
         for (int n = 1; n <= 60; n++) begin
            step();
            if (hit1) begin lat = n; break; end
         end
         $display("clear brick=%0d lat=%0d idx=%0d left=%0d clear=%b", i, lat, hit_index1, bricks_left1, level_clear1);
         total++; if (lat !== i + 2 || hit_index1 !== 6'(i)) begin
            bad++; $display("FAIL lc_hit%0d got lat=%0d idx=%0d want lat=%0d idx=%0d", i, lat, hit_index1, i + 2, i); end
         total++; if (bricks_left1 !== 6'(47 - i) || level_clear1 !== (i == 47)) begin
            bad++; $display("FAIL lc_state%0d got left=%0d clear=%b want left=%0d clear=%b",
                            i, bricks_left1, level_clear1, 47 - i, i == 47); end
      end
      // level_start and refr_tick together: reload wins, twice (dead wall, then live brick 0 under the ball).
      ball_x_l1 = 10'd50;
      ball_y_t1 = 10'd50;
      for (int k = 0; k < 2; k++) begin
         level_start1 = 1'b1;
         refr_tick1   = 1'b1;
         step();
         level_start1 = 1'b0;
         refr_tick1   = 1'b0;
         cyc = 0;
         saw = 1'b0;
         while (scan_busy1 && cyc < 200) begin
            cyc++;
            step();
            if (hit1) saw = 1'b1;
         end
         repeat (3) begin step(); if (hit1) saw = 1'b1; end
         $display("both_pulse%0d busy=%0d hit=%b left=%0d clear=%b", k, cyc, saw, bricks_left1, level_clear1);
         total++; if (cyc !== 48 || saw !== 1'b0) begin
            bad++; $display("FAIL both_pulse%0d got busy=%0d hit=%b want busy=48 hit=0", k, cyc, saw); end
         total++; if (bricks_left1 !== 6'd48 || level_clear1 !== 1'b0) begin
            bad++; $display("FAIL both_pulse%0d_state got left=%0d clear=%b want 48 0", k, bricks_left1, level_clear1); end
      end
   endtask

   initial begin
      level_start = 1'b0; refr_tick = 1'b0; level_start1 = 1'b0; refr_tick1 = 1'b0;
      ball_x_l = '0; ball_y_t = '0; ball_x_l1 = '0; ball_y_t1 = '0;
      pix_x = '0; pix_y = '0;
      test_reset();
      test_load();
      test_hit_brick0();
      test_dead_brick();
      test_worst_latency();
      test_edge_axis();
      test_level_clear();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got_time=%0t want_finish_before=1000000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
